// File: rtl/conv_unit_par.sv
// One output pixel of a D x F x F convolution: LANES-wide MAC over captured operands, then bias, ReLU, saturate.
// Latency BEATS+1 edges from accepted start to done; start is ignored (not queued) while busy.
module conv_unit_par #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int D          = 1,
  parameter int F          = 5,
  parameter int LANES      = 5,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [D*F*F*DATA_WIDTH-1:0]    image,
  input  logic [D*F*F*DATA_WIDTH-1:0]    filter,
  input  logic [DATA_WIDTH-1:0]          bias,
  input  logic                           relu_en,
  output logic                           busy,
  output logic                           done,
  output logic [DATA_WIDTH-1:0]          result
);

  localparam int N     = D * F * F;
  localparam int BEATS = (N + LANES - 1) / LANES;
  localparam int PADW  = BEATS * LANES * DATA_WIDTH;
  localparam int SHW   = LANES * DATA_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_FINAL} state_t;

  state_t                        state_q, state_d;
  logic [PADW-1:0]               img_q, img_d;
  logic [PADW-1:0]               flt_q, flt_d;
  logic [DATA_WIDTH-1:0]         bias_q, bias_d;
  logic                          relu_q, relu_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [BW-1:0]                 beat_q, beat_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic [DATA_WIDTH-1:0]         result_q, result_d;

  logic signed [ACC_WIDTH-1:0]   mac_sum;
  logic signed [ACC_WIDTH-1:0]   bias_ext;
  logic signed [ACC_WIDTH-1:0]   sum_fin;
  logic signed [ACC_WIDTH-1:0]   r_fin;
  logic [DATA_WIDTH-1:0]         sat_res;

  function automatic logic signed [ACC_WIDTH-1:0] mul_ext(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic signed [2*DATA_WIDTH-1:0] ae, be, p;
    ae = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
    be = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
    p  = ae * be;
    return {{(ACC_WIDTH-2*DATA_WIDTH){p[2*DATA_WIDTH-1]}}, p};
  endfunction

  // Operands are shifted down one beat at a time; the zero padding beyond N makes idle lanes add 0.
  always_comb begin
    mac_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      mac_sum = mac_sum + mul_ext(img_q[l*DATA_WIDTH +: DATA_WIDTH],
                                  flt_q[l*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_comb begin
    bias_ext = {{(ACC_WIDTH-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q};
    sum_fin  = acc_q + (bias_ext <<< FRAC_BITS);
    r_fin    = sum_fin >>> FRAC_BITS;
    if (relu_q && r_fin[ACC_WIDTH-1]) begin
      r_fin = '0;
    end
    // In range when every bit above the result sign bit matches it.
    if ((&r_fin[ACC_WIDTH-1:DATA_WIDTH-1]) || !(|r_fin[ACC_WIDTH-1:DATA_WIDTH-1])) begin
      sat_res = r_fin[DATA_WIDTH-1:0];
    end else if (r_fin[ACC_WIDTH-1]) begin
      sat_res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      sat_res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    state_d  = state_q;
    img_d    = img_q;
    flt_d    = flt_q;
    bias_d   = bias_q;
    relu_d   = relu_q;
    acc_d    = acc_q;
    beat_d   = beat_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          img_d   = PADW'(image);
          flt_d   = PADW'(filter);
          bias_d  = bias;
          relu_d  = relu_en;
          acc_d   = '0;
          beat_d  = '0;
          busy_d  = 1'b1;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d  = acc_q + mac_sum;
        img_d  = img_q >> SHW;
        flt_d  = flt_q >> SHW;
        beat_d = beat_q + BW'(1);
        if (beat_q == BW'(BEATS - 1)) begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        result_d = sat_res;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      img_q    <= '0;
      flt_q    <= '0;
      bias_q   <= '0;
      relu_q   <= 1'b0;
      acc_q    <= '0;
      beat_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      img_q    <= img_d;
      flt_q    <= flt_d;
      bias_q   <= bias_d;
      relu_q   <= relu_d;
      acc_q    <= acc_d;
      beat_q   <= beat_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
